// File: rtl/vram_cmd_engine.sv
// vram_cmd_engine: decodes captured EBI bus writes into colour RAM writes.
// A word is one of three things: a direct write, a pointer-based stream write
// with auto-increment, or a command that starts a hardware block fill.
// Define VRAM_FILL_EN to compile in the block-fill engine (LEN/CNT/COLOUR, FILL state).
// Without it, set-LEN and start-fill words are accepted and have no effect.
// In that build busy is constant 0, so overflow can never be set.
module vram_cmd_engine #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       bus_addr,
    input  logic [15:0]       bus_data,
    input  logic              bus_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              overflow
);

    localparam logic [1:0] REG_PTR    = 2'd0;
    localparam logic [1:0] REG_STREAM = 2'd1;
`ifdef VRAM_FILL_EN
    localparam logic [1:0] REG_LEN    = 2'd2;
    localparam logic [1:0] REG_FILL   = 2'd3;
    localparam logic [ADDR_W:0] LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_LAST = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic {IDLE, FILL} state_t;
    state_t state_reg, state_next;

    logic [ADDR_W:0]   len_reg, len_next;
    logic [ADDR_W:0]   cnt_reg, cnt_next;
    logic [DATA_W-1:0] colour_reg, colour_next;
    logic [ADDR_W:0]   len_sat;
`endif

    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0] wr_data_reg, wr_data_next;
    logic              busy_reg, busy_next;
    logic              overflow_reg, overflow_next;

    logic accept;
    logic is_direct;
    logic is_reg;
    logic unused_bits;

    // Many bus bits are don't-care for a given decode; fold them away.
    assign unused_bits = ^{bus_addr, bus_data};

    // busy_reg is exactly the "fill write in this cycle" flag, so it gates acceptance.
    assign accept    = bus_valid & ~busy_reg;
    assign is_direct = accept & (bus_addr[15:14] == 2'b00);
    assign is_reg    = accept & (bus_addr[15:14] == 2'b01);

`ifdef VRAM_FILL_EN
    // Lengths above a full RAM sweep are clamped to exactly one sweep.
    assign len_sat = (bus_data[ADDR_W:0] > LEN_MAX) ? LEN_MAX : bus_data[ADDR_W:0];
`endif

    // Next-state decode: bus word handling, fill sequencing and registered outputs.
    always_comb begin
        ptr_next      = ptr_reg;
        wr_en_next    = 1'b0;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        busy_next     = 1'b0;
        overflow_next = overflow_reg | (bus_valid & busy_reg);
`ifdef VRAM_FILL_EN
        state_next    = state_reg;
        len_next      = len_reg;
        cnt_next      = cnt_reg;
        colour_next   = colour_reg;
`endif
        if (is_direct) begin
            wr_en_next   = 1'b1;
            wr_addr_next = bus_addr[ADDR_W-1:0];
            wr_data_next = bus_data[DATA_W-1:0];
        end else if (is_reg) begin
            case (bus_addr[1:0])
                REG_PTR: begin
                    ptr_next      = bus_data[ADDR_W-1:0];
                    overflow_next = 1'b0;
                end
                REG_STREAM: begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = ptr_reg;
                    wr_data_next = bus_data[DATA_W-1:0];
                    ptr_next     = ptr_reg + 1'b1;
                end
`ifdef VRAM_FILL_EN
                REG_LEN: begin
                    len_next = len_sat;
                end
                REG_FILL: begin
                    // The first fill word is issued on the start edge itself so the
                    // write burst lines up with direct-write latency.
                    if (len_reg != '0) begin
                        colour_next  = bus_data[DATA_W-1:0];
                        wr_en_next   = 1'b1;
                        wr_addr_next = ptr_reg;
                        wr_data_next = bus_data[DATA_W-1:0];
                        ptr_next     = ptr_reg + 1'b1;
                        busy_next    = 1'b1;
                        cnt_next     = len_reg - 1'b1;
                        if (len_reg != CNT_LAST) begin
                            state_next = FILL;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
`ifdef VRAM_FILL_EN
        // Remaining fill words; no bus word is accepted while these are emitted.
        if (state_reg == FILL) begin
            wr_en_next   = 1'b1;
            wr_addr_next = ptr_reg;
            wr_data_next = colour_reg;
            ptr_next     = ptr_reg + 1'b1;
            busy_next    = 1'b1;
            cnt_next     = cnt_reg - 1'b1;
            if (cnt_reg == CNT_LAST) begin
                state_next = IDLE;
            end
        end
`endif
    end

    // State and output registers; reset aborts any fill immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg      <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            busy_reg     <= 1'b0;
            overflow_reg <= 1'b0;
`ifdef VRAM_FILL_EN
            state_reg    <= IDLE;
            len_reg      <= '0;
            cnt_reg      <= '0;
            colour_reg   <= '0;
`endif
        end else begin
            ptr_reg      <= ptr_next;
            wr_en_reg    <= wr_en_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            busy_reg     <= busy_next;
            overflow_reg <= overflow_next;
`ifdef VRAM_FILL_EN
            state_reg    <= state_next;
            len_reg      <= len_next;
            cnt_reg      <= cnt_next;
            colour_reg   <= colour_next;
`endif
        end
    end

    assign wr_en    = wr_en_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign busy     = busy_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_vram_cmd_engine.sv
// tb_vram_cmd_engine: randomized + directed stimulus, scoreboarded RAM writes.
// Expected writes (with the cycle they must appear) go into a queue when each
// bus word is issued; a negedge monitor pops them as the DUT asserts wr_en.
`timescale 1ns/1ps
module tb_vram_cmd_engine;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 12;
    localparam int RAM_SZ = 1 << ADDR_W;
`ifdef VRAM_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       bus_addr;
    logic [15:0]       bus_data;
    logic              bus_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              overflow;

    always #5 clk = ~clk;

    vram_cmd_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_addr (bus_addr),
        .bus_data (bus_data),
        .bus_valid(bus_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .overflow (overflow)
    );

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  cyc    = 0;

    // Reference model state: RAM pointer, fill length, cycles of busy left, sticky flag.
    int m_ptr       = 0;
    int m_len       = 0;
    int m_fill_left = 0;
    bit m_ovf       = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input int c, input int a, input int d);
        wr_t w;
        w.cyc  = c;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Drive one bus slot (called at posedge+1) and advance the model over the next edge.
    task automatic step(input bit v, input logic [15:0] a, input logic [15:0] d);
        bit busy_now;
        int lv;
        bus_valid = v;
        bus_addr  = a;
        bus_data  = d;
        busy_now  = (m_fill_left > 0);
        if (m_fill_left > 0) m_fill_left--;
        if (v && busy_now) begin
            m_ovf = 1'b1;
        end else if (v && a[15:14] == 2'b00) begin
            push_wr(cyc + 1, int'(a[9:0]), int'(d[11:0]));
        end else if (v && a[15:14] == 2'b01) begin
            case (a[1:0])
                2'd0: begin
                    m_ptr = int'(d[9:0]);
                    m_ovf = 1'b0;
                end
                2'd1: begin
                    push_wr(cyc + 1, m_ptr, int'(d[11:0]));
                    m_ptr = (m_ptr + 1) % RAM_SZ;
                end
                2'd2: begin
                    lv = int'(d[10:0]);
                    if (FILL_EN) m_len = (lv > RAM_SZ) ? RAM_SZ : lv;
                end
                default: begin
                    if (FILL_EN && m_len != 0) begin
                        for (int k = 0; k < m_len; k++) begin
                            push_wr(cyc + 1 + k, m_ptr, int'(d[11:0]));
                            m_ptr = (m_ptr + 1) % RAM_SZ;
                        end
                        m_fill_left = m_len;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
        bus_valid = 1'b0;
        check("busy", {31'd0, busy}, {31'd0, (m_fill_left > 0)});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 16'h0000);
    endtask

    // Asynchronous reset from mid-cycle: outputs must drop before the next edge.
    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        m_ptr = 0;
        m_len = 0;
        m_fill_left = 0;
        m_ovf = 1'b0;
        #1;
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: every write the DUT presents must match the next expected one, on time.
    always @(negedge clk) begin
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL missing_write: got none expected addr %0h data %0h at cycle %0d",
                         exp_q[0].addr, exp_q[0].data, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (wr_en) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write (cycle %0d)",
                             wr_addr, wr_data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (int'(wr_addr) != mon_e.addr || int'(wr_data) != mon_e.data || cyc != mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL ram_write: got addr %0h data %0h cycle %0d expected addr %0h data %0h cycle %0d",
                                 wr_addr, wr_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rd;
        int          op;
        reset     = 1'b1;
        bus_valid = 1'b0;
        bus_addr  = 16'h0000;
        bus_data  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wr_en", {31'd0, wr_en}, 32'd0);
        check("reset_wr_addr", {22'd0, wr_addr}, 32'd0);
        check("reset_wr_data", {20'd0, wr_data}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        reset = 1'b0;

        // Direct write.
        step(1'b1, 16'h0123, 16'h0ABC);
        idle(2);

        // Stream writes with pointer wrap.
        step(1'b1, 16'h4000, 16'h03FE);
        step(1'b1, 16'h4001, 16'h0111);
        step(1'b1, 16'h4001, 16'h0222);
        step(1'b1, 16'h4001, 16'h0333);
        step(1'b1, 16'h4001, 16'h0444);
        idle(2);

        // Fill of 5 then a stream write after it.
        step(1'b1, 16'h4002, 16'h0005);
        step(1'b1, 16'h4000, 16'h0010);
        step(1'b1, 16'h4003, 16'h0F00);
        idle(5);
        step(1'b1, 16'h4001, 16'h0555);
        idle(2);

        // Drops during a fill of 4 on its 2nd and 4th cycles, then clear via set-PTR.
        step(1'b1, 16'h4002, 16'h0004);
        step(1'b1, 16'h4003, 16'h00A5);
        step(1'b0, 16'h0000, 16'h0000);
        step(1'b1, 16'h0200, 16'h0DEF);
        step(1'b0, 16'h0000, 16'h0000);
        step(1'b1, 16'h0201, 16'h0DEE);
        step(1'b1, 16'h0202, 16'h0DED);
        idle(2);
        step(1'b1, 16'h4000, 16'h0100);
        idle(1);

        // LEN=0 start is a no-op; LEN=0x7FF saturates to a full sweep.
        step(1'b1, 16'h4002, 16'h0000);
        step(1'b1, 16'h4003, 16'h0123);
        idle(2);
        step(1'b1, 16'h4000, 16'h0155);
        step(1'b1, 16'h4002, 16'h07FF);
        step(1'b1, 16'h4003, 16'h0777);
        idle(RAM_SZ + 1);
        step(1'b1, 16'h4001, 16'h0999);
        idle(2);

        // Ignored 1x words.
        step(1'b1, 16'h8123, 16'h0FFF);
        step(1'b1, 16'hC001, 16'h0EEE);
        idle(2);

        // Reset on the 3rd cycle of a LEN=8 fill, with a dropped word pending.
        step(1'b1, 16'h4002, 16'h0008);
        step(1'b1, 16'h4003, 16'h0321);
        step(1'b1, 16'h0001, 16'h0001);
        step(1'b0, 16'h0000, 16'h0000);
        do_reset();
        step(1'b1, 16'h0123, 16'h0ABC);
        step(1'b1, 16'h4001, 16'h0246);
        idle(2);

        // Randomized mix of all word types.
        for (int i = 0; i < 700; i++) begin
            op = int'($urandom_range(0, 9));
            rd = 16'($urandom);
            ra = 16'($urandom);
            case (op)
                0, 1, 2, 3: ra[15:14] = 2'b00;
                4, 5: ra = {2'b01, ra[13:2], 2'd1};
                6: ra = {2'b01, ra[13:2], 2'd0};
                7: begin
                    ra = {2'b01, ra[13:2], 2'd2};
                    rd = 16'($urandom_range(0, 12));
                end
                8: ra = {2'b01, ra[13:2], 2'd3};
                default: ra[15] = 1'b1;
            endcase
            step($urandom_range(0, 3) != 0, ra, rd);
        end
        idle(20);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
